// File: rtl/blink_pkg.sv
// Shared types and default timing constants for the blinker / blink monitor pair.
package blink_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    STUCK   = 2'd3
  } mon_state_t;

  localparam int CNT_W_DEF       = 25;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int MIN_HALF_DEF    = 1;
  localparam int MAX_HALF_DEF    = 2**24;
  localparam int LOCK_COUNT_DEF  = 4;

endpackage

// File: rtl/blink_monitor_sync_edge_detect.sv
// Synchronizes the asynchronous blink line and produces registered edge pulses.
module sync_edge_detect
  import blink_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic blink_in,
  output logic level,
  output logic edge_rise,
  output logic edge_fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level_d;
  logic                   rise_q;
  logic                   fall_q;

  assign level = sync[SYNC_STAGES-1];

  // Extra pulse stage keeps edge outputs SYNC_STAGES+1 edges behind the capture edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync      <= '0;
      level_d   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      edge_rise <= 1'b0;
      edge_fall <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], blink_in};
      level_d   <= sync[SYNC_STAGES-1];
      rise_q    <= sync[SYNC_STAGES-1] & ~level_d;
      fall_q    <= ~sync[SYNC_STAGES-1] & level_d;
      edge_rise <= rise_q;
      edge_fall <= fall_q;
    end
  end

endmodule

// File: rtl/blink_monitor.sv
// Measures blink half-periods, checks them against a window, tracks lock and stuck line.
// state   | meaning
// IDLE    | no edge seen since reset
// MEASURE | measuring, counting consecutive good half-periods
// LOCKED  | LOCK_COUNT good half-periods seen in a row
// STUCK   | no edge within MAX_HALF+1 cycles
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int MIN_HALF    = MIN_HALF_DEF,
  parameter int MAX_HALF    = MAX_HALF_DEF,
  parameter int LOCK_COUNT  = LOCK_COUNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  input  logic             clear,
  output logic             level,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             stuck,
  output logic             out_of_range
);

  localparam int               GW     = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] SAT    = CNT_W'(MAX_HALF + 1);
  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_HALF);
  localparam logic [GW-1:0]    LOCK_V = GW'(LOCK_COUNT);

  logic             edge_any;
  logic             timeout;
  logic             in_range;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;
  mon_state_t       state;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .blink_in (blink_in),
    .level    (level),
    .edge_rise(edge_rise),
    .edge_fall(edge_fall)
  );

  assign edge_any = edge_rise | edge_fall;
  assign timeout  = (cnt == SAT);
  assign in_range = (cnt >= MIN_V) && (cnt <= MAX_V);

  // Interval counter: restarts at 1 after an edge, so its value on the next edge is t1 - t0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (edge_any) begin
      cnt <= CNT_W'(1);
    end else if (cnt != SAT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      stuck        <= 1'b0;
      out_of_range <= 1'b0;
      good_cnt     <= '0;
    end else begin
      period_valid <= 1'b0;
      // Set events below are written later, so they win over a same-cycle clear.
      if (clear) begin
        stuck        <= 1'b0;
        out_of_range <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (edge_any) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end else if (timeout) begin
            state    <= STUCK;
            stuck    <= 1'b1;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (edge_any) begin
            half_period  <= cnt;
            period_valid <= 1'b1;
            if (in_range) begin
              if (good_cnt + GW'(1) == LOCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
              good_cnt <= good_cnt + GW'(1);
            end else begin
              out_of_range <= 1'b1;
              good_cnt     <= '0;
            end
          end else if (timeout) begin
            state    <= STUCK;
            stuck    <= 1'b1;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        LOCKED: begin
          if (edge_any) begin
            half_period  <= cnt;
            period_valid <= 1'b1;
            if (!in_range) begin
              state        <= MEASURE;
              locked       <= 1'b0;
              good_cnt     <= '0;
              out_of_range <= 1'b1;
            end
          end else if (timeout) begin
            state    <= STUCK;
            stuck    <= 1'b1;
            locked   <= 1'b0;
            good_cnt <= '0;
          end
        end
        STUCK: begin
          if (edge_any) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_monitor.sv
// Directed self-checking bench for blink_monitor (CNT_W=8, MIN_HALF=4, MAX_HALF=20, LOCK_COUNT=3).
module tb_blink_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       blink_in;
  logic       clear;
  logic       level;
  logic       edge_rise;
  logic       edge_fall;
  logic [7:0] half_period;
  logic       period_valid;
  logic       locked;
  logic       stuck;
  logic       out_of_range;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int pv_v[$];
  bit pv_lk[$];
  bit pv_oor[$];
  int pv_cyc[$];
  bit ed_r[$];

  blink_monitor #(
    .CNT_W      (8),
    .SYNC_STAGES(2),
    .MIN_HALF   (4),
    .MAX_HALF   (20),
    .LOCK_COUNT (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .blink_in    (blink_in),
    .clear       (clear),
    .level       (level),
    .edge_rise   (edge_rise),
    .edge_fall   (edge_fall),
    .half_period (half_period),
    .period_valid(period_valid),
    .locked      (locked),
    .stuck       (stuck),
    .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder samples 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (period_valid) begin
      pv_v.push_back(int'(half_period));
      pv_lk.push_back(locked);
      pv_oor.push_back(out_of_range);
      pv_cyc.push_back(cyc);
    end
    if (edge_rise | edge_fall) ed_r.push_back(edge_rise);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic half(input int n);
    blink_in = ~blink_in;
    repeat (n) step();
  endtask

  task automatic clear_q();
    pv_v.delete();
    pv_lk.delete();
    pv_oor.delete();
    pv_cyc.delete();
    ed_r.delete();
  endtask

  function automatic logic [14:0] all_outs();
    return {level, edge_rise, edge_fall, half_period, period_valid, locked, stuck, out_of_range};
  endfunction

  int  exp3_v[5]  = '{10, 2, 10, 10, 10};
  bit  exp3_lk[5] = '{1, 0, 0, 0, 1};
  bit  exp3_oo[5] = '{0, 1, 1, 1, 1};
  bit  exp2_ed[4] = '{1, 0, 1, 0};
  bit  found;
  bit  lk_prev;
  bit  lk_at;
  int  stuck_cyc;
  int  last_pv;

  initial begin
    rst      = 1'b0;
    blink_in = 1'b0;
    clear    = 1'b0;

    // 1: reset holds everything at 0 while blink_in toggles
    for (int i = 0; i < 6; i++) begin
      blink_in = ~blink_in;
      step();
    end
    blink_in = 1'b0;
    step();
    chk("reset_outs", 32'(all_outs()), 0);
    rst = 1'b1;
    repeat (3) step();
    clear_q();
    blink_in = 1'b1;
    step();
    step();
    step();
    chk("edge_not_yet", 32'(edge_rise), 0);
    step();
    chk("edge_rise_lat3", 32'(edge_rise), 1);
    step();
    chk("first_edge_no_pv", 32'(pv_v.size()), 0);
    repeat (5) step();

    // 2: 10-cycle square wave locks on the third measured half
    repeat (3) half(10);
    chk("sq_pv_count", 32'(pv_v.size()), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sq_hp_%0d", i), (pv_v.size() > i) ? 32'(pv_v[i]) : 32'hffff_ffff, 10);
      chk($sformatf("sq_lk_%0d", i), (pv_lk.size() > i) ? 32'(pv_lk[i]) : 32'hffff_ffff,
          (i == 2) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("edge_kind_%0d", i), (ed_r.size() > i) ? 32'(ed_r[i]) : 32'hffff_ffff,
          32'(exp2_ed[i]));
    clear_q();

    // 3: short half while locked unlocks, three good halves relock
    half(2);
    repeat (4) half(10);
    chk("glitch_pv_count", 32'(pv_v.size()), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("glitch_hp_%0d", i), (pv_v.size() > i) ? 32'(pv_v[i]) : 32'hffff_ffff,
          32'(exp3_v[i]));
      chk($sformatf("glitch_lk_%0d", i), (pv_lk.size() > i) ? 32'(pv_lk[i]) : 32'hffff_ffff,
          32'(exp3_lk[i]));
      chk($sformatf("glitch_oor_%0d", i), (pv_oor.size() > i) ? 32'(pv_oor[i]) : 32'hffff_ffff,
          32'(exp3_oo[i]));
    end

    // 5: clear drops out_of_range; clear coincident with a set loses
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_oor", 32'(out_of_range), 0);
    chk("clear_keeps_lock", 32'(locked), 1);
    half(3);
    blink_in = ~blink_in;
    repeat (4) step();
    chk("oor_edge_pulse", 32'(edge_rise | edge_fall), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("set_beats_clear_pv", 32'(period_valid), 1);
    chk("set_beats_clear_hp", 32'(half_period), 3);
    chk("set_beats_clear_oor", 32'(out_of_range), 1);
    chk("oor_unlock", 32'(locked), 0);
    step();
    chk("oor_sticky", 32'(out_of_range), 1);
    repeat (4) step();

    // 4: relock, then hold the line until stuck
    clear_q();
    repeat (3) half(10);
    chk("relock_pv_count", 32'(pv_v.size()), 3);
    chk("relock_locked", 32'(locked), 1);
    last_pv   = (pv_cyc.size() > 0) ? pv_cyc[pv_cyc.size()-1] : 0;
    found     = 1'b0;
    lk_prev   = locked;
    lk_at     = 1'b1;
    stuck_cyc = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (stuck) begin
        found     = 1'b1;
        stuck_cyc = cyc;
        lk_at     = locked;
      end else begin
        lk_prev = locked;
      end
    end
    chk("stuck_seen", 32'(found), 1);
    chk("stuck_delay", 32'(stuck_cyc - last_pv), 21);
    chk("stuck_unlock", 32'(lk_at), 0);
    chk("locked_before_stuck", 32'(lk_prev), 1);
    clear_q();
    half(8);
    chk("post_stuck_no_pv", 32'(pv_v.size()), 0);
    half(8);
    chk("post_stuck_pv_count", 32'(pv_v.size()), 1);
    chk("post_stuck_hp", (pv_v.size() > 0) ? 32'(pv_v[0]) : 32'hffff_ffff, 8);
    chk("stuck_sticky", 32'(stuck), 1);

    // 6: asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_reset_outs", 32'(all_outs()), 0);
    blink_in = 1'b0;
    step();
    step();
    rst = 1'b1;
    repeat (3) step();
    clear_q();
    half(10);
    chk("after_reset_edges", 32'(ed_r.size()), 1);
    chk("after_reset_no_pv", 32'(pv_v.size()), 0);
    chk("after_reset_hp", 32'(half_period), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
